ram_rr_arbiter: RTL and testbench



---
 rtl/ram_rr_arbiter_if.sv | 49 ++++
 rtl/ram_rr_arbiter.sv | 113 +++++++++++
 tb/tb_ram_rr_arbiter.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/ram_rr_arbiter_if.sv
// Bus bundle between two RAM requesters, the round-robin controller and the RAM.
// The slave modport is the controller's view; master is the requester/RAM side.
interface ram_rr_arbiter_if #(
    parameter int AW = 4,
    parameter int DW = 4
);
    logic          M0_REQ;
    logic          M0_WR;
    logic [AW-1:0] M0_A;
    logic [DW-1:0] M0_D;
    logic          M0_GNT;
    logic          M0_RVALID;
    logic [DW-1:0] M0_RDATA;

    logic          M1_REQ;
    logic          M1_WR;
    logic [AW-1:0] M1_A;
    logic [DW-1:0] M1_D;
    logic          M1_GNT;
    logic          M1_RVALID;
    logic [DW-1:0] M1_RDATA;

    logic          RAM_EN;
    logic          RAM_WR;
    logic [AW-1:0] RAM_A;
    logic [DW-1:0] RAM_D;
    logic [DW-1:0] RAM_Q;
    logic          INIT_DONE;

    modport slave (
        input  M0_REQ, M0_WR, M0_A, M0_D,
        output M0_GNT, M0_RVALID, M0_RDATA,
        input  M1_REQ, M1_WR, M1_A, M1_D,
        output M1_GNT, M1_RVALID, M1_RDATA,
        output RAM_EN, RAM_WR, RAM_A, RAM_D,
        input  RAM_Q,
        output INIT_DONE
    );

    modport master (
        output M0_REQ, M0_WR, M0_A, M0_D,
        input  M0_GNT, M0_RVALID, M0_RDATA,
        output M1_REQ, M1_WR, M1_A, M1_D,
        input  M1_GNT, M1_RVALID, M1_RDATA,
        input  RAM_EN, RAM_WR, RAM_A, RAM_D,
        output RAM_Q,
        input  INIT_DONE
    );
endinterface

// File: rtl/ram_rr_arbiter.sv
// Clears a single-port synchronous RAM after reset, then shares it between two
// requesters with round-robin arbitration and routes read data back to its issuer.
module ram_rr_arbiter #(
    parameter int            AW       = 4,
    parameter int            DW       = 4,
    parameter logic [DW-1:0] INIT_VAL = '0
) (
    input  logic            CLK,
    input  logic            RST,
    ram_rr_arbiter_if.slave bus
);
    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] init_cnt_q, init_cnt_d;
    logic          rr_ptr_q, rr_ptr_d;
    logic          init_done_q, init_done_d;
    logic          rd_valid_q, rd_valid_d;
    logic          rd_owner_q, rd_owner_d;

    logic          gnt0, gnt1;
    logic          ram_en, ram_wr;
    logic [AW-1:0] ram_a;
    logic [DW-1:0] ram_d;

    always_comb begin
        state_d     = state_q;
        init_cnt_d  = init_cnt_q;
        rr_ptr_d    = rr_ptr_q;
        init_done_d = init_done_q;
        rd_valid_d  = 1'b0;
        rd_owner_d  = rd_owner_q;
        gnt0        = 1'b0;
        gnt1        = 1'b0;
        ram_en      = 1'b0;
        ram_wr      = 1'b0;
        ram_a       = '0;
        ram_d       = '0;

        case (state_q)
            ST_INIT: begin
                ram_en     = 1'b1;
                ram_wr     = 1'b1;
                ram_a      = init_cnt_q;
                ram_d      = INIT_VAL;
                init_cnt_d = init_cnt_q + AW'(1);
                if (init_cnt_q == {AW{1'b1}}) begin
                    state_d     = ST_RUN;
                    init_done_d = 1'b1;
                end
            end
            ST_RUN: begin
                // rr_ptr names the requester that wins a tie; it always points at the last loser.
                gnt0 = bus.M0_REQ && (!bus.M1_REQ || !rr_ptr_q);
                gnt1 = bus.M1_REQ && (!bus.M0_REQ || rr_ptr_q);
                if (gnt0) begin
                    ram_en     = 1'b1;
                    ram_wr     = bus.M0_WR;
                    ram_a      = bus.M0_A;
                    ram_d      = bus.M0_D;
                    rr_ptr_d   = 1'b1;
                    rd_valid_d = !bus.M0_WR;
                    rd_owner_d = 1'b0;
                end else if (gnt1) begin
                    ram_en     = 1'b1;
                    ram_wr     = bus.M1_WR;
                    ram_a      = bus.M1_A;
                    ram_d      = bus.M1_D;
                    rr_ptr_d   = 1'b0;
                    rd_valid_d = !bus.M1_WR;
                    rd_owner_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= ST_INIT;
            init_cnt_q  <= '0;
            rr_ptr_q    <= 1'b0;
            init_done_q <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_owner_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            rr_ptr_q    <= rr_ptr_d;
            init_done_q <= init_done_d;
            rd_valid_q  <= rd_valid_d;
            rd_owner_q  <= rd_owner_d;
        end
    end

    // RAM_Q is only meaningful in the cycle after an accepted read, so gate it per owner.
    assign bus.M0_GNT    = gnt0;
    assign bus.M1_GNT    = gnt1;
    assign bus.M0_RVALID = rd_valid_q && !rd_owner_q;
    assign bus.M1_RVALID = rd_valid_q && rd_owner_q;
    assign bus.M0_RDATA  = (rd_valid_q && !rd_owner_q) ? bus.RAM_Q : '0;
    assign bus.M1_RDATA  = (rd_valid_q && rd_owner_q) ? bus.RAM_Q : '0;
    assign bus.RAM_EN    = ram_en;
    assign bus.RAM_WR    = ram_wr;
    assign bus.RAM_A     = ram_a;
    assign bus.RAM_D     = ram_d;
    assign bus.INIT_DONE = init_done_q;
endmodule

// File: tb/tb_ram_rr_arbiter.sv
// Directed bench for ram_rr_arbiter with a behavioural 16x4 RAM (MASK = 15).
// Inputs change 1 time unit after posedge; outputs are sampled at negedge.
module tb_ram_rr_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    ram_rr_arbiter_if #(.AW(4), .DW(4)) bus ();

    ram_rr_arbiter #(.AW(4), .DW(4), .INIT_VAL(4'h0)) dut (
        .CLK(clk),
        .RST(rst),
        .bus(bus)
    );

    logic [3:0] mem [16];
    logic [3:0] ram_q = 4'h0;
    always @(posedge clk) begin
        if (bus.RAM_EN) begin
            if (bus.RAM_WR) mem[bus.RAM_A] <= bus.RAM_D & 4'hF;
            else            ram_q <= mem[bus.RAM_A];
        end
    end
    assign bus.RAM_Q = ram_q;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input logic r0, input logic w0, input logic [3:0] a0, input logic [3:0] d0,
                           input logic r1, input logic w1, input logic [3:0] a1, input logic [3:0] d1);
        bus.M0_REQ = r0; bus.M0_WR = w0; bus.M0_A = a0; bus.M0_D = d0;
        bus.M1_REQ = r1; bus.M1_WR = w1; bus.M1_A = a1; bus.M1_D = d1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check_init_cycle(input int k);
        chk($sformatf("init_en[%0d]", k), 32'(bus.RAM_EN), 32'd1);
        chk($sformatf("init_wr[%0d]", k), 32'(bus.RAM_WR), 32'd1);
        chk($sformatf("init_a[%0d]", k), 32'(bus.RAM_A), 32'(k));
        chk($sformatf("init_d[%0d]", k), 32'(bus.RAM_D), 32'd0);
        chk($sformatf("init_done_low[%0d]", k), 32'(bus.INIT_DONE), 32'd0);
        chk($sformatf("init_gnt0[%0d]", k), 32'(bus.M0_GNT), 32'd0);
        chk($sformatf("init_gnt1[%0d]", k), 32'(bus.M1_GNT), 32'd0);
    endtask

    initial begin
        set_req(0, 0, 0, 0, 0, 0, 0, 0);

        // Reset and full init sweep; M0 raises a read of A=0 during INIT cycle 5.
        next_cycle();
        next_cycle();
        @(negedge clk);
        chk("rst_init_done", 32'(bus.INIT_DONE), 32'd0);
        chk("rst_rvalid0", 32'(bus.M0_RVALID), 32'd0);
        chk("rst_rvalid1", 32'(bus.M1_RVALID), 32'd0);
        rst = 1'b0;
        check_init_cycle(0);
        for (int k = 1; k < 16; k++) begin
            next_cycle();
            if (k == 5) set_req(1, 0, 4'd0, 0, 0, 0, 0, 0);
            @(negedge clk);
            check_init_cycle(k);
        end
        $display("txn: init sweep of 16 addresses");
        next_cycle();
        @(negedge clk);
        chk("run_init_done", 32'(bus.INIT_DONE), 32'd1);
        chk("run_first_gnt0", 32'(bus.M0_GNT), 32'd1);
        chk("run_first_ram_wr", 32'(bus.RAM_WR), 32'd0);

        // M0 reads every address back to back; all must be zero.
        for (int a = 1; a < 16; a++) begin
            next_cycle();
            bus.M0_A = 4'(a);
            @(negedge clk);
            chk($sformatf("clr_gnt0[%0d]", a), 32'(bus.M0_GNT), 32'd1);
            chk($sformatf("clr_rv0[%0d]", a), 32'(bus.M0_RVALID), 32'd1);
            chk($sformatf("clr_rd0[%0d]", a), 32'(bus.M0_RDATA), 32'd0);
        end
        next_cycle();
        set_req(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("clr_last_rv0", 32'(bus.M0_RVALID), 32'd1);
        chk("clr_last_rd0", 32'(bus.M0_RDATA), 32'd0);
        chk("idle_ram_en", 32'(bus.RAM_EN), 32'd0);
        chk("idle_ram_a", 32'(bus.RAM_A), 32'd0);
        $display("txn: M0 read-back of cleared RAM");

        // M0 write A=3 D=5, then read A=3.
        next_cycle();
        set_req(1, 1, 4'd3, 4'd5, 0, 0, 0, 0);
        @(negedge clk);
        chk("wr3_gnt0", 32'(bus.M0_GNT), 32'd1);
        chk("wr3_ram", {bus.RAM_EN, bus.RAM_WR, 2'b00, bus.RAM_A, bus.RAM_D}, {1'b1, 1'b1, 2'b00, 4'd3, 4'd5});
        next_cycle();
        bus.M0_WR = 1'b0;
        @(negedge clk);
        chk("rd3_gnt0", 32'(bus.M0_GNT), 32'd1);
        chk("wr3_no_rvalid", 32'(bus.M0_RVALID), 32'd0);
        next_cycle();
        set_req(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("rd3_rv0", 32'(bus.M0_RVALID), 32'd1);
        chk("rd3_rd0", 32'(bus.M0_RDATA), 32'd5);
        chk("rd3_rv1", 32'(bus.M1_RVALID), 32'd0);
        next_cycle();
        @(negedge clk);
        chk("rd3_pulse_end", 32'(bus.M0_RVALID), 32'd0);
        $display("txn: M0 write A=3 D=5 then read 5");

        // M1 writes 7..10 to A=12..15, then reads them back to back.
        for (int j = 0; j < 4; j++) begin
            next_cycle();
            set_req(0, 0, 0, 0, 1, 1, 4'(12 + j), 4'(7 + j));
            @(negedge clk);
            chk($sformatf("m1wr_gnt1[%0d]", j), 32'(bus.M1_GNT), 32'd1);
            chk($sformatf("m1wr_gnt0[%0d]", j), 32'(bus.M0_GNT), 32'd0);
        end
        for (int j = 0; j < 4; j++) begin
            next_cycle();
            set_req(0, 0, 0, 0, 1, 0, 4'(12 + j), 0);
            @(negedge clk);
            chk($sformatf("m1rd_gnt1[%0d]", j), 32'(bus.M1_GNT), 32'd1);
            chk($sformatf("m1rd_rv1[%0d]", j), 32'(bus.M1_RVALID), (j == 0) ? 32'd0 : 32'd1);
            chk($sformatf("m1rd_rd1[%0d]", j), 32'(bus.M1_RDATA), (j == 0) ? 32'd0 : 32'(6 + j));
            chk($sformatf("m1rd_rv0[%0d]", j), 32'(bus.M0_RVALID), 32'd0);
        end
        next_cycle();
        set_req(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("m1rd_last_rv1", 32'(bus.M1_RVALID), 32'd1);
        chk("m1rd_last_rd1", 32'(bus.M1_RDATA), 32'd10);
        next_cycle();
        @(negedge clk);
        chk("m1rd_pulse_end", 32'(bus.M1_RVALID), 32'd0);
        $display("txn: M1 write/read A=12..15 data 7..10");

        // Seed A=1 (M0) and A=2 (M1), then six cycles of full contention on reads.
        next_cycle();
        set_req(1, 1, 4'd1, 4'hA, 0, 0, 0, 0);
        next_cycle();
        set_req(0, 0, 0, 0, 1, 1, 4'd2, 4'd6);
        for (int c = 0; c < 6; c++) begin
            next_cycle();
            set_req(1, 0, 4'd1, 0, 1, 0, 4'd2, 0);
            @(negedge clk);
            chk($sformatf("rr_gnt0[%0d]", c), 32'(bus.M0_GNT), (c % 2 == 0) ? 32'd1 : 32'd0);
            chk($sformatf("rr_gnt1[%0d]", c), 32'(bus.M1_GNT), (c % 2 == 1) ? 32'd1 : 32'd0);
            if (c > 0) begin
                chk($sformatf("rr_rv0[%0d]", c), 32'(bus.M0_RVALID), (c % 2 == 1) ? 32'd1 : 32'd0);
                chk($sformatf("rr_rv1[%0d]", c), 32'(bus.M1_RVALID), (c % 2 == 0) ? 32'd1 : 32'd0);
                chk($sformatf("rr_rd0[%0d]", c), 32'(bus.M0_RDATA), (c % 2 == 1) ? 32'hA : 32'd0);
                chk($sformatf("rr_rd1[%0d]", c), 32'(bus.M1_RDATA), (c % 2 == 0) ? 32'd6 : 32'd0);
            end
        end
        next_cycle();
        set_req(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("rr_last_rv1", 32'(bus.M1_RVALID), 32'd1);
        chk("rr_last_rd1", 32'(bus.M1_RDATA), 32'd6);
        chk("rr_last_rv0", 32'(bus.M0_RVALID), 32'd0);
        $display("txn: contention M0/M1 reads, 6 alternating grants");

        // M0 read of A=1 meets RST at its accepting edge: no pulse, full re-clear.
        next_cycle();
        set_req(1, 0, 4'd1, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("rst_rd_gnt0", 32'(bus.M0_GNT), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("rst2_rv0", 32'(bus.M0_RVALID), 32'd0);
        chk("rst2_rv1", 32'(bus.M1_RVALID), 32'd0);
        chk("rst2_init_done", 32'(bus.INIT_DONE), 32'd0);
        rst = 1'b0;
        check_init_cycle(0);
        for (int k = 1; k < 16; k++) begin
            next_cycle();
            @(negedge clk);
            check_init_cycle(k);
        end
        next_cycle();
        @(negedge clk);
        chk("rst2_run_gnt0", 32'(bus.M0_GNT), 32'd1);
        chk("rst2_run_init_done", 32'(bus.INIT_DONE), 32'd1);
        next_cycle();
        bus.M0_A = 4'd2;
        @(negedge clk);
        chk("rst2_rd1_rv0", 32'(bus.M0_RVALID), 32'd1);
        chk("rst2_rd1_rd0", 32'(bus.M0_RDATA), 32'd0);
        next_cycle();
        set_req(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("rst2_rd2_rv0", 32'(bus.M0_RVALID), 32'd1);
        chk("rst2_rd2_rd0", 32'(bus.M0_RDATA), 32'd0);
        $display("txn: reset mid-read, re-clear, old data reads 0");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
